// File: rtl/dram_portb_ctrl.sv
// RAM port-B command controller: word read, byte-masked write and block fill, with word-address range checking.
// Build option DRAM_PORTB_CTRL_READBACK_EN adds a one-cycle VERIFY readback after every in-range write.
module dram_portb_ctrl #(
  parameter int LEN_W      = 12,
  parameter int WORD_LIMIT = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [29:0]      cmd_addr,
  input  logic [31:0]      cmd_wdata,
  input  logic [3:0]       cmd_be,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic [29:0]      ram_addrb,
  output logic [3:0]       ram_web,
  output logic [31:0]      ram_dinb,
  input  logic [31:0]      ram_doutb,
  output logic             busy
);
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_FILL  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd5;
`ifdef DRAM_PORTB_CTRL_READBACK_EN
  localparam logic [2:0] ST_VERIFY = 3'd4;
`endif
  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [30:0] LIMIT   = 31'(WORD_LIMIT);

  logic [2:0]       state;
  logic [1:0]       op_q;
  logic [29:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;
  logic [LEN_W-1:0] cnt_q;
  logic [31:0]      rdata_q;
  logic             err_q;
  logic             in_range;
  logic             addr_max;

  // One extra bit so a limit of 2^30 words still compares correctly.
  assign in_range = {1'b0, addr_q} < LIMIT;
  assign addr_max = &addr_q;

`ifdef DRAM_PORTB_CTRL_READBACK_EN
  logic [31:0] be_mask;
  assign be_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (cmd_valid) begin
          op_q    <= cmd_op;
          addr_q  <= cmd_addr;
          wdata_q <= cmd_wdata;
          be_q    <= cmd_be;
          cnt_q   <= cmd_len;
          case (cmd_op)
            OP_READ:  state <= ST_READ;
            OP_WRITE: state <= ST_WRITE;
            OP_FILL: begin
              if (cmd_len == '0) begin
                state   <= ST_RESP;
                rdata_q <= '0;
                err_q   <= 1'b0;
              end else begin
                state <= ST_FILL;
              end
            end
            default: begin
              state   <= ST_RESP;
              rdata_q <= '0;
              err_q   <= 1'b1;
            end
          endcase
        end
        ST_READ: begin
          rdata_q <= (in_range && op_q == OP_READ) ? ram_doutb : '0;
          err_q   <= !in_range;
          state   <= ST_RESP;
        end
        ST_WRITE: begin
`ifdef DRAM_PORTB_CTRL_READBACK_EN
          if (in_range) begin
            state <= ST_VERIFY;
          end else begin
            state   <= ST_RESP;
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
`else
          state   <= ST_RESP;
          rdata_q <= '0;
          err_q   <= !in_range;
`endif
        end
`ifdef DRAM_PORTB_CTRL_READBACK_EN
        ST_VERIFY: begin
          state   <= ST_RESP;
          rdata_q <= '0;
          err_q   <= |((ram_doutb ^ wdata_q) & be_mask);
        end
`endif
        ST_FILL: begin
          if (!in_range) begin
            state   <= ST_RESP;
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) begin
              state   <= ST_RESP;
              rdata_q <= '0;
              err_q   <= 1'b0;
            end else if (addr_max) begin
              // More words remain but the address space is exhausted; never wrap to 0.
              state   <= ST_RESP;
              rdata_q <= '0;
              err_q   <= 1'b1;
            end else begin
              addr_q <= addr_q + 30'd1;
            end
          end
        end
        ST_RESP: if (rsp_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Port-B drive is decoded from state so reset silences the RAM immediately.
  always_comb begin
    ram_addrb = '0;
    ram_web   = '0;
    ram_dinb  = '0;
    case (state)
      ST_READ: ram_addrb = addr_q;
      ST_WRITE, ST_FILL: begin
        ram_addrb = addr_q;
        ram_dinb  = wdata_q;
        ram_web   = in_range ? be_q : 4'h0;
      end
`ifdef DRAM_PORTB_CTRL_READBACK_EN
      ST_VERIFY: ram_addrb = addr_q;
`endif
      default: ;
    endcase
  end
endmodule

// File: doc/dram_portb_ctrl.md
DRAM_PORTB_CTRL -- requirements
Module: dram_portb_ctrl

Interface
REQ-001 The block SHALL have parameter LEN_W, default 12, giving the fill-length field width in bits.
REQ-002 The block SHALL have parameter WORD_LIMIT, default 4096, giving the number of valid RAM words; word addresses at or above it are out of range.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 cmd_valid  in  1  command present.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid & cmd_ready are both high at posedge clk.
REQ-007 cmd_op  in  2  00 read word, 01 write word, 10 fill block, 11 reserved.
REQ-008 cmd_addr  in  30  word address [31:2].
REQ-009 cmd_wdata  in  32  write or fill data.
REQ-010 cmd_be  in  4  byte enables for write and fill.
REQ-011 cmd_len  in  LEN_W  fill word count.
REQ-012 rsp_valid  out  1  response present; held until rsp_ready.
REQ-013 rsp_ready  in  1  response consumed.
REQ-014 rsp_rdata  out  32  read data; 0 for non-read ops and on error.
REQ-015 rsp_err  out  1  command failed (range error, reserved op, or readback mismatch).
REQ-016 ram_addrb  out  30  RAM port-B word address.
REQ-017 ram_web  out  4  RAM port-B byte write enables.
REQ-018 ram_dinb  out  32  RAM port-B write data.
REQ-019 ram_doutb  in  32  RAM port-B combinational read data.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 The state machine SHALL have states IDLE, READ, WRITE, FILL, VERIFY and RESP.
REQ-022 cmd_ready SHALL be high only in IDLE; on acceptance, the op, addr, wdata, be and len fields SHALL be registered.
REQ-023 From IDLE, an accepted command SHALL transition as follows: op 00 to READ; op 01 to WRITE; op 10 to FILL; op 11 to RESP with rsp_err=1 and no RAM write.
REQ-024 READ SHALL drive ram_addrb with web=0 for one cycle, capture ram_doutb into rsp_rdata, then go to RESP; rsp_valid SHALL rise 2 cycles after the accept edge.
REQ-025 WRITE SHALL drive addr, dinb=wdata and web=be for exactly one cycle, then go to RESP, or to VERIFY when REQ-040 applies.
REQ-026 FILL SHALL write one word per cycle at addr, addr+1, and so on, for cmd_len words, with web=be, then go to RESP.
REQ-027 A FILL with cmd_len=0 SHALL perform no writes and go directly to RESP with rsp_err=0.
REQ-028 A range check SHALL apply wherever a target word address is at or above WORD_LIMIT, or addr[31:14] is nonzero (WORD_LIMIT=4096):
- READ or WRITE: SHALL issue no write, return rdata=0 and err=1.
- FILL: SHALL stop before the first out-of-range word, keep the words already written, and report err=1.
REQ-029 FILL address arithmetic SHALL be 30-bit, SHALL never wrap to 0, and SHALL be governed by REQ-028.
REQ-030 RESP SHALL hold rsp_valid=1 with stable rdata and err until rsp_ready is high, then return to IDLE; cmd_ready SHALL be 0 during that return edge.
REQ-031 ram_web SHALL be 0 in every state other than WRITE and FILL.
REQ-032 ram_addrb and ram_dinb SHALL be 0 in IDLE and RESP.
REQ-033 rsp_rdata and rsp_err SHALL update only on entering RESP.

Reset
REQ-034 Asserting rst_n=0 SHALL force state IDLE asynchronously, in any state including mid-FILL.
REQ-035 On reset, the following SHALL be 0: rsp_valid, rsp_err, rsp_rdata, ram_web, ram_addrb, ram_dinb, busy and the internal counters.
REQ-036 cmd_ready SHALL be 1 during reset.
REQ-037 A command interrupted by reset SHALL produce no response, and no further writes SHALL occur after reset assertion.
REQ-038 After rst_n deasserts, the first command SHALL be acceptable at the first posedge.

Configuration
REQ-039 The macro DRAM_PORTB_CTRL_READBACK_EN SHALL select write verification.
REQ-040 With DRAM_PORTB_CTRL_READBACK_EN defined, WRITE SHALL enter VERIFY for one cycle with web=0 at the same addr, then go to RESP. VERIFY SHALL compare ram_doutb against wdata on enabled bytes only and set rsp_err=1 on mismatch; write latency becomes 3 cycles.
REQ-041 Without DRAM_PORTB_CTRL_READBACK_EN, the VERIFY state SHALL be absent and write latency SHALL be 2 cycles.

Verification
REQ-042 Write then read: write addr 0x010, wdata 0xDEADBEEF, be 0xF; then read 0x010 -> rsp_rdata=0xDEADBEEF, err=0, read rsp_valid 2 cycles after accept.
REQ-043 Byte write: with word 0x020 holding 0x11223344, write wdata 0xAABBCCDD, be 0x5; then read -> 0x11BB33DD.
REQ-044 Fill to limit: fill addr 0xFFE, len 4, wdata 0x5A5A5A5A -> words 0xFFE and 0xFFF are written, err=1, exactly 2 web-active cycles; fill len 0 -> no writes, err=0.
REQ-045 Range and reserved: read addr 0x4000 -> rdata=0, err=1; op 11 -> err=1 with ram_web never nonzero; hold rsp_ready=0 for 5 cycles -> rsp_valid and data stay stable and cmd_ready stays 0.
REQ-046 Reset mid-FILL: assert rst_n low in the 3rd cycle of a fill of len 10 -> ram_web=0 immediately, no response, and a subsequent read of the 3rd target word returns its old value.
REQ-047 Readback (macro defined): force ram_doutb mismatch in VERIFY -> err=1; with the macro undefined, write latency is 2 cycles.
